// File: rtl/chacha_keystream.sv
// ChaCha keystream generator: accepts one key/nonce/start-counter job and streams nblocks
// consecutive 512-bit keystream blocks through a one-deep valid/ready output register.
module chacha_keystream #(
    parameter int ROUNDS = 20,
    parameter int UNROLL = 1,
    parameter int IETF   = 0
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         cfg_valid,
    output logic         cfg_ready,
    input  logic [255:0] key,
    input  logic [95:0]  nonce,
    input  logic [63:0]  counter,
    input  logic [31:0]  nblocks,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [511:0] out_data,
    output logic [63:0]  out_counter,
    output logic         out_last,
    output logic         busy
);
    typedef logic [15:0][31:0] state_t;

    localparam int         NUM_STEPS = ROUNDS / UNROLL;
    localparam logic [4:0] LAST_STEP = 5'(NUM_STEPS - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ROUND = 2'd1;
    localparam logic [1:0] S_FINAL = 2'd2;

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] bswap(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    function automatic state_t quarter(input state_t s, input logic [3:0] a, input logic [3:0] b,
                                       input logic [3:0] c, input logic [3:0] d);
        state_t t;
        t    = s;
        t[a] = t[a] + t[b];
        t[d] = rotl(t[d] ^ t[a], 16);
        t[c] = t[c] + t[d];
        t[b] = rotl(t[b] ^ t[c], 12);
        t[a] = t[a] + t[b];
        t[d] = rotl(t[d] ^ t[a], 8);
        t[c] = t[c] + t[d];
        t[b] = rotl(t[b] ^ t[c], 7);
        return t;
    endfunction

    function automatic state_t columnRound(input state_t s);
        state_t t;
        t = quarter(s, 4'd0, 4'd4, 4'd8,  4'd12);
        t = quarter(t, 4'd1, 4'd5, 4'd9,  4'd13);
        t = quarter(t, 4'd2, 4'd6, 4'd10, 4'd14);
        t = quarter(t, 4'd3, 4'd7, 4'd11, 4'd15);
        return t;
    endfunction

    function automatic state_t diagonalRound(input state_t s);
        state_t t;
        t = quarter(s, 4'd0, 4'd5, 4'd10, 4'd15);
        t = quarter(t, 4'd1, 4'd6, 4'd11, 4'd12);
        t = quarter(t, 4'd2, 4'd7, 4'd8,  4'd13);
        t = quarter(t, 4'd3, 4'd4, 4'd9,  4'd14);
        return t;
    endfunction

    // Key and nonce arrive big-endian by byte; the state holds them as little-endian words.
    function automatic state_t buildState(input logic [255:0] k, input logic [95:0] n, input logic [63:0] c);
        state_t s;
        s[0] = 32'h61707865;
        s[1] = 32'h3320646e;
        s[2] = 32'h79622d32;
        s[3] = 32'h6b206574;
        for (int i = 0; i < 8; i++) begin
            s[4+i] = bswap(k[255-32*i -: 32]);
        end
        s[12] = c[31:0];
        if (IETF != 0) begin
            s[13] = bswap(n[95:64]);
        end else begin
            s[13] = c[63:32];
        end
        s[14] = bswap(n[63:32]);
        s[15] = bswap(n[31:0]);
        return s;
    endfunction

    logic [1:0]   state_q, state_d;
    logic [4:0]   step_q, step_d;
    logic [31:0]  remaining_q, remaining_d;
    logic [63:0]  blockCtr_q, blockCtr_d;
    logic [255:0] key_q, key_d;
    logic [95:0]  nonce_q, nonce_d;
    state_t       work_q, work_d;
    logic         outValid_q, outValid_d;
    logic [511:0] outData_q, outData_d;
    logic [63:0]  outCounter_q, outCounter_d;
    logic         outLast_q, outLast_d;

    logic [63:0]  ctrLoad, ctrNext;
    state_t       initState, loadState, roundState;
    logic [511:0] ksData;

    generate
        if (UNROLL == 2) begin : g_unroll2
            assign roundState = diagonalRound(columnRound(work_q));
        end else begin : g_unroll1
            assign roundState = step_q[0] ? diagonalRound(work_q) : columnRound(work_q);
        end
    endgenerate

    // IETF keeps the counter 32 bits wide, so the upper half stays zero and wraps mod 2^32.
    always_comb begin
        ctrLoad   = (IETF != 0) ? {32'd0, counter[31:0]} : counter;
        ctrNext   = (IETF != 0) ? {32'd0, blockCtr_q[31:0] + 32'd1} : blockCtr_q + 64'd1;
        initState = buildState(key_q, nonce_q, blockCtr_q);
        loadState = (state_q == S_IDLE) ? buildState(key, nonce, ctrLoad)
                                        : buildState(key_q, nonce_q, ctrNext);
        ksData    = '0;
        for (int k = 0; k < 16; k++) begin
            ksData[511-32*k -: 32] = bswap(work_q[k] + initState[k]);
        end
    end

    always_comb begin
        state_d      = state_q;
        step_d       = step_q;
        remaining_d  = remaining_q;
        blockCtr_d   = blockCtr_q;
        key_d        = key_q;
        nonce_d      = nonce_q;
        work_d       = work_q;
        outValid_d   = outValid_q;
        outData_d    = outData_q;
        outCounter_d = outCounter_q;
        outLast_d    = outLast_q;
        if (outValid_q && out_ready) begin
            outValid_d = 1'b0;
        end
        case (state_q)
            S_IDLE: begin
                if (cfg_valid && nblocks != 32'd0) begin
                    key_d       = key;
                    nonce_d     = nonce;
                    blockCtr_d  = ctrLoad;
                    remaining_d = nblocks;
                    work_d      = loadState;
                    step_d      = 5'd0;
                    state_d     = S_ROUND;
                end
            end
            S_ROUND: begin
                work_d = roundState;
                step_d = step_q + 5'd1;
                if (step_q == LAST_STEP) begin
                    state_d = S_FINAL;
                end
            end
            S_FINAL: begin
                // The finished state is frozen here until the output register can take it.
                if (!outValid_q || out_ready) begin
                    outValid_d   = 1'b1;
                    outData_d    = ksData;
                    outCounter_d = blockCtr_q;
                    outLast_d    = (remaining_q == 32'd1);
                    if (remaining_q > 32'd1) begin
                        blockCtr_d  = ctrNext;
                        remaining_d = remaining_q - 32'd1;
                        work_d      = loadState;
                        step_d      = 5'd0;
                        state_d     = S_ROUND;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            step_q       <= '0;
            remaining_q  <= '0;
            blockCtr_q   <= '0;
            key_q        <= '0;
            nonce_q      <= '0;
            work_q       <= '0;
            outValid_q   <= 1'b0;
            outData_q    <= '0;
            outCounter_q <= '0;
            outLast_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            step_q       <= step_d;
            remaining_q  <= remaining_d;
            blockCtr_q   <= blockCtr_d;
            key_q        <= key_d;
            nonce_q      <= nonce_d;
            work_q       <= work_d;
            outValid_q   <= outValid_d;
            outData_q    <= outData_d;
            outCounter_q <= outCounter_d;
            outLast_q    <= outLast_d;
        end
    end

    assign cfg_ready   = (state_q == S_IDLE);
    assign out_valid   = outValid_q;
    assign out_data    = outData_q;
    assign out_counter = outCounter_q;
    assign out_last    = outLast_q;
    assign busy        = (state_q != S_IDLE) || outValid_q;

endmodule
